qcs_nhtp_rd_seq: RTL and testbench

- Read-address sequencer sitting directly upstream of the dynamic preamble generator.
- On a start pulse it latches the TX bandwidth and walks the non-HT preamble sample ROM: STF symbols first, then LTF symbols.
- It drives nhtp_raddr, nhtp_re and nhtp_ltf into the generator, one sample per cycle.
- It honours a downstream stall and supports abort.

---
 rtl/qcs_nhtp_pkg.sv | 38 +++
 rtl/qcs_nhtp_addr_ctr.sv | 46 ++++
 rtl/qcs_nhtp_rd_seq.sv | 172 +++++++++++++++++
 tb/tb_qcs_nhtp_rd_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcs_nhtp_pkg.sv
// Shared types and constants for the non-HT preamble read sequencer.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package qcs_nhtp_pkg;

  localparam int ADDR_W   = 10;
  localparam int BW_W     = 2;
  localparam int SYM_LEN  = 64;
  localparam int STF_SYMS = 2;
  localparam int LTF_SYMS = 2;

  // Symbol counter only needs to reach the larger of the two repetition counts.
  localparam int SYMS_MAX  = (STF_SYMS > LTF_SYMS) ? STF_SYMS : LTF_SYMS;
  localparam int SYM_CNT_W = (SYMS_MAX > 1) ? $clog2(SYMS_MAX) : 1;

  localparam logic [ADDR_W-1:0] STF_BASE = '0;
  localparam logic [ADDR_W-1:0] LTF_BASE = ADDR_W'(512);

  typedef enum logic [BW_W-1:0] {
    BW_20  = 2'd0,
    BW_40  = 2'd1,
    BW_80  = 2'd2,
    BW_160 = 2'd3
  } bw_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STF  = 2'd1,
    LTF  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // Samples per symbol at the given bandwidth: 64/128/256/512.
  function automatic logic [ADDR_W-1:0] sym_len(input bw_e bw);
    return ADDR_W'(SYM_LEN) << bw;
  endfunction

endpackage

// File: rtl/qcs_nhtp_addr_ctr.sv
// Sample index and symbol counter for one preamble region (STF or LTF).
// Latency: flags and next index are combinational from the registered counters.
// Backpressure: counters hold whenever i_adv is low (downstream stall).
module qcs_nhtp_addr_ctr
  import qcs_nhtp_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_adv,
  input  logic [ADDR_W-1:0]    i_sym_len_m1,
  input  logic [SYM_CNT_W-1:0] i_syms_m1,
  output logic [ADDR_W-1:0]    o_idx_nxt,
  output logic                 o_wrap,
  output logic                 o_last_sym
);

  logic [ADDR_W-1:0]    r_idx;
  logic [SYM_CNT_W-1:0] r_sym;
  logic                 w_wrap;
  logic                 w_last_sym;

  assign w_wrap     = (r_idx == i_sym_len_m1);
  assign w_last_sym = (r_sym == i_syms_m1);
  assign o_wrap     = w_wrap;
  assign o_last_sym = w_last_sym;
  assign o_idx_nxt  = w_wrap ? '0 : (r_idx + ADDR_W'(1));

  // Step the sample index each accepted read; the symbol counter steps on a
  // wrap and folds back to 0 after the last symbol so the next region starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_sym <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
      r_sym <= '0;
    end else if (i_adv) begin
      r_idx <= o_idx_nxt;
      if (w_wrap) begin
        r_sym <= w_last_sym ? '0 : (r_sym + SYM_CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/qcs_nhtp_rd_seq.sv
// Walks the non-HT preamble ROM (STF symbols then LTF symbols) feeding the preamble generator.
// Latency: start sampled at edge N gives the first read (addr 0) in cycle N+1; one read per cycle after.
// Backpressure: rd_stall drops nhtp_re next cycle and freezes address/counters until it clears.
module qcs_nhtp_rd_seq
  import qcs_nhtp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [BW_W-1:0]   txconfig_bw,
  input  logic [BW_W-1:0]   sys_bw_mode,
  input  logic              rd_stall,
  output logic [ADDR_W-1:0] nhtp_raddr,
  output logic              nhtp_re,
  output logic              nhtp_ltf,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  bw_e                 r_bw;
  logic [ADDR_W-1:0]   r_raddr;
  logic                r_re;
  logic                r_ltf;
  logic                r_busy;
  logic                r_done;
  logic                r_cfg_err;

  logic [ADDR_W-1:0]    w_raddr_nxt;
  logic                 w_re_nxt;
  logic                 w_ltf_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_cfg_err_nxt;
  logic                 w_bw_ld;
  logic                 w_ctr_clr;
  logic                 w_ctr_adv;
  logic [ADDR_W-1:0]    w_sym_len_m1;
  logic [SYM_CNT_W-1:0] w_syms_m1;
  logic [ADDR_W-1:0]    w_idx_nxt;
  logic                 w_wrap;
  logic                 w_last_sym;
  logic                 w_phase_end;

  assign w_sym_len_m1 = sym_len(r_bw) - ADDR_W'(1);
  assign w_syms_m1    = (r_state == LTF) ? SYM_CNT_W'(LTF_SYMS - 1) : SYM_CNT_W'(STF_SYMS - 1);
  assign w_phase_end  = w_wrap && w_last_sym;

  qcs_nhtp_addr_ctr u_addr_ctr (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_ctr_clr),
    .i_adv        (w_ctr_adv),
    .i_sym_len_m1 (w_sym_len_m1),
    .i_syms_m1    (w_syms_m1),
    .o_idx_nxt    (w_idx_nxt),
    .o_wrap       (w_wrap),
    .o_last_sym   (w_last_sym)
  );

  // Bandwidth is captured only on an accepted start so mid-sequence config changes are harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bw <= BW_20;
    end else if (w_bw_ld) begin
      r_bw <= bw_e'(txconfig_bw);
    end
  end

  // State and all outputs are registered together; the outputs describe the read issued this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_raddr   <= '0;
      r_re      <= 1'b0;
      r_ltf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_raddr   <= w_raddr_nxt;
      r_re      <= w_re_nxt;
      r_ltf     <= w_ltf_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  // Next-state and next-output decode; abort outranks stall and start, a stall holds everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_raddr_nxt   = r_raddr;
    w_re_nxt      = 1'b0;
    w_ltf_nxt     = r_ltf;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_cfg_err_nxt = 1'b0;
    w_bw_ld       = 1'b0;
    w_ctr_clr     = 1'b0;
    w_ctr_adv     = 1'b0;

    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          if (txconfig_bw <= sys_bw_mode) begin
            w_state_nxt = STF;
            w_bw_ld     = 1'b1;
            w_ctr_clr   = 1'b1;
            w_raddr_nxt = STF_BASE;
            w_re_nxt    = 1'b1;
            w_ltf_nxt   = 1'b0;
            w_busy_nxt  = 1'b1;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end

      STF, LTF: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_ctr_clr   = 1'b1;
          w_raddr_nxt = STF_BASE;
          w_ltf_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
        end else if (!rd_stall) begin
          w_ctr_adv = 1'b1;
          if (w_phase_end && (r_state == LTF)) begin
            // Last LTF read has gone out: report completion.
            w_state_nxt = DONE;
            w_raddr_nxt = STF_BASE;
            w_ltf_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else if (w_phase_end) begin
            // Seamless hop into the LTF region; the index has wrapped to 0.
            w_state_nxt = LTF;
            w_raddr_nxt = LTF_BASE + w_idx_nxt;
            w_ltf_nxt   = 1'b1;
            w_re_nxt    = 1'b1;
          end else begin
            w_raddr_nxt = ((r_state == LTF) ? LTF_BASE : STF_BASE) + w_idx_nxt;
            w_re_nxt    = 1'b1;
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
        w_ctr_clr   = 1'b1;
      end

      default: begin
        w_state_nxt = IDLE;
        w_ctr_clr   = 1'b1;
      end
    endcase
  end

  assign nhtp_raddr = r_raddr;
  assign nhtp_re    = r_re;
  assign nhtp_ltf   = r_ltf;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_qcs_nhtp_rd_seq.sv
// Directed bench for the non-HT preamble read sequencer.
// Latency: observes outputs on the falling edge, one cycle after inputs are sampled.
// Backpressure: exercises rd_stall holds and abort over stall.
module tb_qcs_nhtp_rd_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       rd_stall;
  logic [1:0] txconfig_bw;
  logic [1:0] sys_bw_mode;
  logic [9:0] nhtp_raddr;
  logic       nhtp_re;
  logic       nhtp_ltf;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qcs_nhtp_rd_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .txconfig_bw (txconfig_bw),
    .sys_bw_mode (sys_bw_mode),
    .rd_stall    (rd_stall),
    .nhtp_raddr  (nhtp_raddr),
    .nhtp_re     (nhtp_re),
    .nhtp_ltf    (nhtp_ltf),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; rd_stall = 1'b0;
    txconfig_bw = 2'd0; sys_bw_mode = 2'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({nhtp_raddr, nhtp_re, nhtp_ltf, busy, done, cfg_err} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_hold outputs got %h expected 0",
               {nhtp_raddr, nhtp_re, nhtp_ltf, busy, done, cfg_err});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({nhtp_raddr, nhtp_re, nhtp_ltf, busy, done, cfg_err} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_release outputs got %h expected 0",
               {nhtp_raddr, nhtp_re, nhtp_ltf, busy, done, cfg_err});
    end
  endtask

  // Full unstalled sequence: 2 STF symbols then 2 LTF symbols of 64<<bw samples.
  task automatic test_full_seq(input int bw);
    int sl;
    int tot;
    int r;
    logic [13:0] exp_v;
    logic [13:0] obs_v;
    logic [2:0]  exp3;
    logic [2:0]  obs3;
    sl = 64 << bw;
    tot = 4 * sl;
    txconfig_bw = 2'(bw); sys_bw_mode = 2'd3; start = 1'b1;
    for (int c = 1; c <= tot + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= tot) begin
        r = c - 1;
        exp_v = {1'b1, (r >= 2 * sl), 1'b1, 1'b0,
                 10'((r < 2 * sl) ? (r % sl) : (512 + r % sl))};
        obs_v = {nhtp_re, nhtp_ltf, busy, done, nhtp_raddr};
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_err++;
          $display("FAIL full_seq bw=%0d cyc=%0d {re,ltf,busy,done,addr} got %b/%0d expected %b/%0d",
                   bw, c, obs_v[13:10], obs_v[9:0], exp_v[13:10], exp_v[9:0]);
        end
      end else begin
        exp3 = {1'b0, 1'b0, (c == tot + 1)};
        obs3 = {nhtp_re, busy, done};
        n_cmp++;
        if (obs3 !== exp3) begin
          n_err++;
          $display("FAIL full_seq_end bw=%0d cyc=%0d {re,busy,done} got %b expected %b",
                   bw, c, obs3, exp3);
        end
      end
    end
  endtask

  task automatic test_cfg_err();
    txconfig_bw = 2'd2; sys_bw_mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({cfg_err, nhtp_re, busy, done} !== 4'b1000) begin
      n_err++;
      $display("FAIL cfg_err_pulse {cfg_err,re,busy,done} got %b expected 1000",
               {cfg_err, nhtp_re, busy, done});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({cfg_err, nhtp_re, busy, done} !== 4'b0000) begin
        n_err++;
        $display("FAIL cfg_err_after cyc=%0d {cfg_err,re,busy,done} got %b expected 0000",
                 c, {cfg_err, nhtp_re, busy, done});
      end
    end
  endtask

  // Stall for three cycles while STF address 63 is presented.
  task automatic test_stall();
    int r;
    logic [13:0] exp_v;
    logic [13:0] obs_v;
    logic [2:0]  exp3;
    logic [2:0]  obs3;
    txconfig_bw = 2'd0; sys_bw_mode = 2'd3; start = 1'b1;
    for (int c = 1; c <= 262; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 259) begin
        if (c <= 64) begin
          r = c - 1;
        end else if (c <= 67) begin
          r = -1;
        end else begin
          r = c - 4;
        end
        if (r < 0) begin
          exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 10'd63};
        end else begin
          exp_v = {1'b1, (r >= 128), 1'b1, 1'b0,
                   10'((r < 128) ? (r % 64) : (512 + r % 64))};
        end
        obs_v = {nhtp_re, nhtp_ltf, busy, done, nhtp_raddr};
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_err++;
          $display("FAIL stall cyc=%0d {re,ltf,busy,done,addr} got %b/%0d expected %b/%0d",
                   c, obs_v[13:10], obs_v[9:0], exp_v[13:10], exp_v[9:0]);
        end
      end else begin
        exp3 = {1'b0, 1'b0, (c == 260)};
        obs3 = {nhtp_re, busy, done};
        n_cmp++;
        if (obs3 !== exp3) begin
          n_err++;
          $display("FAIL stall_end cyc=%0d {re,busy,done} got %b expected %b", c, obs3, exp3);
        end
      end
      rd_stall = (c >= 64) && (c <= 66);
    end
    rd_stall = 1'b0;
  endtask

  // Abort at LTF address 520, restart two cycles later, then abort together with a stall.
  task automatic test_abort();
    int r;
    logic [13:0] exp_v;
    logic [13:0] obs_v;
    txconfig_bw = 2'd0; sys_bw_mode = 2'd3; start = 1'b1;
    for (int c = 1; c <= 144; c++) begin
      @(negedge clk);
      if (c <= 137) begin
        r = c - 1;
        exp_v = {1'b1, (r >= 128), 1'b1, 1'b0,
                 10'((r < 128) ? (r % 64) : (512 + r % 64))};
      end else if (c == 140) begin
        exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 10'd0};
      end else begin
        exp_v = 14'd0;
      end
      obs_v = {nhtp_re, nhtp_ltf, busy, done, nhtp_raddr};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL abort cyc=%0d {re,ltf,busy,done,addr} got %b/%0d expected %b/%0d",
                 c, obs_v[13:10], obs_v[9:0], exp_v[13:10], exp_v[9:0]);
      end
      abort    = (c == 137) || (c == 140);
      rd_stall = (c == 140);
      start    = (c == 139);
    end
    abort = 1'b0; rd_stall = 1'b0; start = 1'b0;
  endtask

  task automatic test_start_abort_idle();
    txconfig_bw = 2'd0; sys_bw_mode = 2'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({nhtp_re, busy, done, cfg_err} !== 4'b0000) begin
        n_err++;
        $display("FAIL start_abort_ok cyc=%0d {re,busy,done,cfg_err} got %b expected 0000",
                 c, {nhtp_re, busy, done, cfg_err});
      end
    end
    txconfig_bw = 2'd2; sys_bw_mode = 2'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if ({nhtp_re, busy, done, cfg_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL start_abort_bad {re,busy,done,cfg_err} got %b expected 0000",
               {nhtp_re, busy, done, cfg_err});
    end
  endtask

  // Starts during a sequence (one legal at bw=3, one over the ceiling) must be ignored.
  task automatic test_start_busy();
    int r;
    logic [14:0] exp_v;
    logic [14:0] obs_v;
    txconfig_bw = 2'd0; sys_bw_mode = 2'd3; start = 1'b1;
    for (int c = 1; c <= 259; c++) begin
      @(negedge clk);
      if (c <= 256) begin
        r = c - 1;
        exp_v = {1'b1, (r >= 128), 1'b1, 1'b0, 1'b0,
                 10'((r < 128) ? (r % 64) : (512 + r % 64))};
      end else begin
        exp_v = {1'b0, 1'b0, 1'b0, (c == 257), 1'b0, 10'd0};
      end
      obs_v = {nhtp_re, nhtp_ltf, busy, done, cfg_err, nhtp_raddr};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_err++;
        $display("FAIL start_busy cyc=%0d {re,ltf,busy,done,cfg_err,addr} got %b/%0d expected %b/%0d",
                 c, obs_v[14:10], obs_v[9:0], exp_v[14:10], exp_v[9:0]);
      end
      start = (c == 10) || (c == 20);
      txconfig_bw = (c == 10) ? 2'd3 : ((c == 20) ? 2'd2 : 2'd0);
      sys_bw_mode = (c == 20) ? 2'd1 : 2'd3;
    end
    start = 1'b0; txconfig_bw = 2'd0; sys_bw_mode = 2'd3;
  endtask

  task automatic test_reset_mid();
    txconfig_bw = 2'd0; sys_bw_mode = 2'd3; start = 1'b1;
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if ({nhtp_re, busy, nhtp_raddr} !== {1'b1, 1'b1, 10'd19}) begin
      n_err++;
      $display("FAIL reset_mid_pre {re,busy,addr} got %b%b/%0d expected 11/19",
               nhtp_re, busy, nhtp_raddr);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({nhtp_raddr, nhtp_re, nhtp_ltf, busy, done, cfg_err} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_mid_async outputs got %h expected 0",
               {nhtp_raddr, nhtp_re, nhtp_ltf, busy, done, cfg_err});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({nhtp_re, busy, done} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_mid_after cyc=%0d {re,busy,done} got %b expected 000",
                 c, {nhtp_re, busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_seq(0);
    test_full_seq(3);
    test_cfg_err();
    test_stall();
    test_abort();
    test_start_abort_idle();
    test_start_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
